// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: resolves EX branches against the carried-down prediction,
// issues a registered redirect plus a timed flush on mispredict, and queues
// BTB write-backs behind a small FIFO that drives the BTB update port.
// Optional statistics counters are enabled with `define BTB_UPDATE_STATS_EN.
module btb_update_ctrl #(
    parameter int unsigned ENTRY_NUM    = 8192,
    parameter int unsigned INDEX_BITS   = $clog2(ENTRY_NUM),
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  resolve_valid,
    output logic                  resolve_ready,
    input  logic [31:0]           resolve_pc,
    input  logic [INDEX_BITS-1:0] resolve_index,
    input  logic                  pred_hit,
    input  logic                  pred_taken,
    input  logic [31:0]           pred_target,
    input  logic                  actual_taken,
    input  logic [31:0]           actual_target,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  flush,
    output logic                  update_en,
    input  logic                  btb_wr_ready,
    output logic [INDEX_BITS-1:0] update_index,
    output logic [31:0]           update_pc,
    output logic [31:0]           update_target
`ifdef BTB_UPDATE_STATS_EN
    ,
    output logic [31:0]           stat_resolved,
    output logic [31:0]           stat_mispredict
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FL_W  = $clog2(FLUSH_CYCLES + 1);

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic [31:0]           pc;
        logic [31:0]           target;
    } upd_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state, state_d;
    logic [FL_W-1:0]     fcnt, fcnt_d;
    logic                redirect_valid_d;
    logic [31:0]         redirect_pc_d;
    logic                flush_d;

    upd_entry_t          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    logic                fifo_full;
    logic                accepted;
    logic                in_idle;
    logic                mispredict;
    logic [31:0]         correct_pc;
    logic                push;
    logic                pop;

    // Handshake, mispredict detection and FIFO push/pop qualification.
    always_comb begin
        fifo_full     = (count == CNT_W'(FIFO_DEPTH));
        resolve_ready = !reset && !fifo_full;
        accepted      = resolve_valid && resolve_ready;
        in_idle       = (state == IDLE);
        mispredict    = (pred_taken != actual_taken) ||
                        (actual_taken && pred_taken && (pred_target != actual_target));
        correct_pc    = actual_taken ? actual_target : (resolve_pc + 32'd4);
        // Wrong-path resolves during FLUSH are accepted but never allocate.
        push          = accepted && in_idle && actual_taken &&
                        !(pred_hit && (pred_target == actual_target));
        pop           = update_en && btb_wr_ready;
    end

    // Queue head drives the BTB write port directly.
    always_comb begin
        update_en     = (count != '0);
        update_index  = fifo_mem[rd_ptr].index;
        update_pc     = fifo_mem[rd_ptr].pc;
        update_target = fifo_mem[rd_ptr].target;
    end

    // Pending-update FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{index: resolve_index, pc: resolve_pc, target: actual_target};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Redirect/flush next-state and next-output logic.
    always_comb begin
        state_d          = state;
        fcnt_d           = fcnt;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        flush_d          = 1'b0;
        case (state)
            IDLE: begin
                if (accepted && mispredict) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = correct_pc;
                    flush_d          = 1'b1;
                    fcnt_d           = FL_W'(FLUSH_CYCLES - 1);
                    state_d          = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (fcnt == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d  = fcnt - FL_W'(1);
                    flush_d = 1'b1;
                end
            end
        endcase
    end

    // FSM state and registered redirect/flush outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            fcnt           <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            state          <= state_d;
            fcnt           <= fcnt_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
        end
    end

`ifdef BTB_UPDATE_STATS_EN
    // Saturating counters of on-path resolves and issued redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (accepted && in_idle && (stat_resolved != 32'hFFFF_FFFF)) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (redirect_valid_d && (stat_mispredict != 32'hFFFF_FFFF)) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: single-resolve vector table plus
// hand sequences for flush window, backpressure and reset mid-flush.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        resolve_valid;
    logic        resolve_ready;
    logic [31:0] resolve_pc;
    logic [12:0] resolve_index;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        update_en;
    logic        btb_wr_ready;
    logic [12:0] update_index;
    logic [31:0] update_pc;
    logic [31:0] update_target;
`ifdef BTB_UPDATE_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispredict;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .resolve_valid (resolve_valid),
        .resolve_ready (resolve_ready),
        .resolve_pc    (resolve_pc),
        .resolve_index (resolve_index),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .actual_taken  (actual_taken),
        .actual_target (actual_target),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .update_en     (update_en),
        .btb_wr_ready  (btb_wr_ready),
        .update_index  (update_index),
        .update_pc     (update_pc),
        .update_target (update_target)
`ifdef BTB_UPDATE_STATS_EN
        ,
        .stat_resolved  (stat_resolved),
        .stat_mispredict(stat_mispredict)
`endif
    );

    typedef struct {
        logic        hit;
        logic        ptaken;
        logic [31:0] ptgt;
        logic        ataken;
        logic [31:0] atgt;
        logic [31:0] pc;
        logic [12:0] idx;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_enq;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hit, input logic pt, input logic [31:0] ptgt,
                         input logic at, input logic [31:0] atgt,
                         input logic [31:0] pc, input logic [12:0] idx);
        resolve_valid = 1'b1;
        pred_hit      = hit;
        pred_taken    = pt;
        pred_target   = ptgt;
        actual_taken  = at;
        actual_target = atgt;
        resolve_pc    = pc;
        resolve_index = idx;
    endtask

    function automatic vec_t mk(input logic hit, input logic pt, input logic [31:0] ptgt,
                                input logic at, input logic [31:0] atgt,
                                input logic [31:0] pc, input logic [12:0] idx,
                                input logic er, input logic [31:0] erpc, input logic eq);
        vec_t v;
        v.hit = hit; v.ptaken = pt; v.ptgt = ptgt; v.ataken = at; v.atgt = atgt;
        v.pc = pc; v.idx = idx; v.exp_redir = er; v.exp_rpc = erpc; v.exp_enq = eq;
        return v;
    endfunction

    initial begin
        //            hit pt ptgt          at atgt          pc            idx       redir rpc          enq
        vecs[0] = mk(1, 1, 32'h0000_0200, 1, 32'h0000_0200, 32'h0000_0100, 13'h0010, 0, 32'h0,         0);
        vecs[1] = mk(0, 0, 32'h0000_0000, 1, 32'h0000_0200, 32'h0000_0100, 13'h0040, 1, 32'h0000_0200, 1);
        vecs[2] = mk(1, 1, 32'h0000_0500, 0, 32'h0000_0000, 32'hFFFF_FFFC, 13'h0011, 1, 32'h0000_0000, 0);
        vecs[3] = mk(0, 0, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0300, 13'h0012, 0, 32'h0,         0);
        vecs[4] = mk(1, 1, 32'h0000_0400, 1, 32'h0000_0440, 32'h0000_0380, 13'h1FFF, 1, 32'h0000_0440, 1);
        vecs[5] = mk(0, 1, 32'h0000_0600, 1, 32'h0000_0600, 32'h0000_05F0, 13'h0005, 0, 32'h0,         1);
        vecs[6] = mk(1, 0, 32'h0000_0700, 1, 32'h0000_0700, 32'h0000_06F0, 13'h0006, 1, 32'h0000_0700, 0);

        reset = 1'b1; resolve_valid = 1'b0; btb_wr_ready = 1'b0;
        resolve_pc = '0; resolve_index = '0; pred_hit = 1'b0; pred_taken = 1'b0;
        pred_target = '0; actual_taken = 1'b0; actual_target = '0;

        // Reset state
        #1;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc",    redirect_pc,         32'd0);
        chk("rst_flush",          32'(flush),          32'd0);
        chk("rst_update_en",      32'(update_en),      32'd0);
        chk("rst_update_pc",      update_pc,           32'd0);
        chk("rst_resolve_ready",  32'(resolve_ready),  32'd0);
        step();
        reset = 1'b0;
        step();

        // Vector table: one resolve from idle/empty, then drain
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].hit, vecs[i].ptaken, vecs[i].ptgt, vecs[i].ataken,
                  vecs[i].atgt, vecs[i].pc, vecs[i].idx);
            chk($sformatf("v%0d_ready", i), 32'(resolve_ready), 32'd1);
            step();
            resolve_valid = 1'b0;
            chk($sformatf("v%0d_redirect", i), 32'(redirect_valid), 32'(vecs[i].exp_redir));
            chk($sformatf("v%0d_flush", i),    32'(flush),          32'(vecs[i].exp_redir));
            chk($sformatf("v%0d_update_en", i), 32'(update_en),     32'(vecs[i].exp_enq));
            if (vecs[i].exp_redir) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
            if (vecs[i].exp_enq) begin
                chk($sformatf("v%0d_upd_index", i),  32'(update_index), 32'(vecs[i].idx));
                chk($sformatf("v%0d_upd_pc", i),     update_pc,         vecs[i].pc);
                chk($sformatf("v%0d_upd_target", i), update_target,     vecs[i].atgt);
            end
            step();
            chk($sformatf("v%0d_redirect_drop", i), 32'(redirect_valid), 32'd0);
            chk($sformatf("v%0d_flush_2nd", i),     32'(flush),          32'(vecs[i].exp_redir));
            step();
            chk($sformatf("v%0d_flush_end", i), 32'(flush), 32'd0);
            btb_wr_ready = 1'b1;
            step();
            btb_wr_ready = 1'b0;
            chk($sformatf("v%0d_drained", i), 32'(update_en), 32'd0);
        end

        // Wrong-path resolves during the flush window are discarded
        drive(0, 0, 32'h0, 1, 32'h0000_2000, 32'h0000_1000, 13'h0003);
        step();
        drive(0, 0, 32'h0, 1, 32'h0000_2200, 32'h0000_1100, 13'h0004);
        chk("wp_redirect",    32'(redirect_valid), 32'd1);
        chk("wp_redirect_pc", redirect_pc,         32'h0000_2000);
        chk("wp_flush1",      32'(flush),          32'd1);
        chk("wp_ready",       32'(resolve_ready),  32'd1);
        step();
        drive(1, 1, 32'h0000_2300, 0, 32'h0, 32'h0000_1200, 13'h0005);
        chk("wp_no_redirect2", 32'(redirect_valid), 32'd0);
        chk("wp_flush2",       32'(flush),          32'd1);
        step();
        resolve_valid = 1'b0;
        chk("wp_flush_end",   32'(flush),          32'd0);
        chk("wp_no_redirect3", 32'(redirect_valid), 32'd0);
        chk("wp_head_pc",     update_pc,           32'h0000_1000);
        btb_wr_ready = 1'b1;
        chk("wp_head_valid",  32'(update_en),      32'd1);
        step();
        chk("wp_single_entry", 32'(update_en), 32'd0);
        btb_wr_ready = 1'b0;
        step();

        // Backpressure: fill with four BTB misses, then drain in order
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 32'h0000_8000 + 32'(k), 1, 32'h0000_8000 + 32'(k),
                  32'h0000_4000 + 32'(k * 16), 13'(k + 32));
            chk($sformatf("bp_ready%0d", k), 32'(resolve_ready), 32'd1);
            step();
        end
        drive(0, 1, 32'h0000_9000, 1, 32'h0000_9000, 32'h0000_9000, 13'h0077);
        chk("bp_full_ready", 32'(resolve_ready), 32'd0);
        chk("bp_no_flush",   32'(flush),         32'd0);
        chk("bp_head0",      update_pc,          32'h0000_4000);
        btb_wr_ready = 1'b1;
        step();
        resolve_valid = 1'b0;
        chk("bp_ready_after_pop", 32'(resolve_ready), 32'd1);
        chk("bp_head1",           update_pc,          32'h0000_4010);
        chk("bp_head1_index",     32'(update_index),  32'd33);
        step();
        chk("bp_head2", update_pc, 32'h0000_4020);
        step();
        chk("bp_head3",        update_pc,     32'h0000_4030);
        chk("bp_head3_target", update_target, 32'h0000_8003);
        step();
        chk("bp_empty", 32'(update_en), 32'd0);
        btb_wr_ready = 1'b0;
        step();

        // Reset during flush with two queued entries
        drive(0, 1, 32'h0000_3100, 1, 32'h0000_3100, 32'h0000_3000, 13'h0021);
        step();
        drive(0, 0, 32'h0, 1, 32'h0000_3300, 32'h0000_3200, 13'h0022);
        step();
        resolve_valid = 1'b0;
        chk("rf_flush_before",  32'(flush),     32'd1);
        chk("rf_queued_before", 32'(update_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rf_flush",          32'(flush),          32'd0);
        chk("rf_update_en",      32'(update_en),      32'd0);
        chk("rf_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rf_resolve_ready",  32'(resolve_ready),  32'd0);
        chk("rf_redirect_pc",    redirect_pc,         32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rf_post_empty", 32'(update_en),     32'd0);
        chk("rf_post_flush", 32'(flush),         32'd0);
        chk("rf_post_ready", 32'(resolve_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
- Branch-resolution side of the BTB: consumes resolved branches from EX, compares them against the prediction carried down the pipe, and flags mispredicts.
- Issues a registered redirect plus a timed flush on every mispredict.
- Queues BTB write-backs (valid/ready) that drive the BTB update port (update_en/update_index/update_pc/update_target).
- Sits between the EX stage and the BTB; fetch consumes its redirect/flush.

Parameters:
- ENTRY_NUM, 8192, BTB entries; must match the BTB instance.
- INDEX_BITS, $clog2(ENTRY_NUM), BTB index width.
- FIFO_DEPTH, 4, pending-update queue depth; power of two, >=2.
- FLUSH_CYCLES, 2, cycles flush is held after a redirect; >=1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- resolve_valid  in  1  EX presents a resolved control-flow instruction.
- resolve_ready  out  1  controller accepts resolve this cycle.
- resolve_pc  in  32  PC of the resolved branch.
- resolve_index  in  INDEX_BITS  BTB index used at prediction time (carried down the pipe).
- pred_hit  in  1  BTB hit at fetch.
- pred_taken  in  1  direction predicted at fetch.
- pred_target  in  32  target predicted at fetch.
- actual_taken  in  1  resolved direction.
- actual_target  in  32  resolved target.
- redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc.
- redirect_pc  out  32  restart address.
- flush  out  1  kill younger in-flight instructions.
- update_en  out  1  queue head valid (BTB write request).
- btb_wr_ready  in  1  BTB accepts the write this cycle.
- update_index  out  INDEX_BITS  head entry index.
- update_pc  out  32  head entry branch PC (BTB derives the tag).
- update_target  out  32  head entry target.

Behaviour:
- Reset (async): FSM=IDLE, FIFO empty, pointers=0.
  - redirect_valid=0, redirect_pc=0, flush=0, update_en=0, update_index/pc/target=0.
  - resolve_ready=0 while reset is asserted.
- Accept: a resolve is accepted when resolve_valid && resolve_ready.
- resolve_ready = !fifo_full. A pop in the same cycle does not free space for that cycle's push.
- Mispredict = (pred_taken != actual_taken) || (actual_taken && pred_taken && pred_target != actual_target).
- Correct PC = actual_taken ? actual_target : resolve_pc+4 (32-bit wrap).
- Enqueue condition: accepted && actual_taken && !(pred_hit && pred_target == actual_target).
  - Pushes {resolve_index, resolve_pc, actual_target}.
  - Not-taken branches never allocate.
- FIFO output: head registered, update_* driven directly from head storage.
  - Pop when update_en && btb_wr_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits.
- Write to BTB is visible to lookups one cycle after the pop cycle (BTB registers it).
- FSM:
  - IDLE: on an accepted mispredict, next cycle redirect_valid=1, redirect_pc=correct PC, flush=1, counter=FLUSH_CYCLES-1; go FLUSH (or IDLE if FLUSH_CYCLES=1).
  - FLUSH: redirect_valid=0, flush=1, counter decrements; at 0 go IDLE, where flush=0.
  - During FLUSH: resolves are accepted (resolve_ready per FIFO rule) but discarded as wrong-path. No enqueue, no redirect.
  - Correctly predicted resolves in IDLE: enqueue only, no redirect.
- Redirect latency: 1 cycle from the accept edge. Flush spans exactly FLUSH_CYCLES cycles starting with the redirect cycle.
- Reset mid-operation: FIFO contents dropped, FSM to IDLE, all outputs to reset values immediately.
- Pending FIFO entries are not cancelled by flush; they belong to older, committed branches.

Optional Feature:
- Macro BTB_UPDATE_STATS_EN.
- Defined: adds outputs stat_resolved[31:0] (counts non-discarded accepted resolves) and stat_mispredict[31:0] (counts redirects issued).
  - Both reset to 0, saturate at 32'hFFFF_FFFF, update one cycle after the event.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Correct taken hit: pred_hit=1, pred_taken=1, pred_target=actual_target=0x200, pc=0x100 -> no redirect, no enqueue, update_en stays 0.
- Taken miss: pred_taken=0, actual_taken=1, pc=0x100, index=0x40, target=0x200 -> next cycle redirect_valid=1, redirect_pc=0x200, flush=1 for 2 cycles. update_en=1 with index=0x40, pc=0x100, target=0x200; pops on btb_wr_ready=1.
- Not-taken mispredict: pred_taken=1, actual_taken=0, pc=0xFFFF_FFFC -> redirect_pc=0x0000_0000 (wrap), no enqueue.
- Wrong path in FLUSH: second resolve with actual_taken=1 during the flush window -> accepted, discarded, FIFO count unchanged, no second redirect.
- Backpressure: btb_wr_ready=0, 4 taken misses-to-BTB -> resolve_ready=0 after 4th. Raise btb_wr_ready -> entries drain in order, resolve_ready=1 after first pop.
- Reset mid-flush: assert reset during FLUSH with 2 queued entries -> flush=0, update_en=0, redirect_valid=0 immediately; after release, FIFO empty.
